ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 110 +++++++++++
 tb/tb_ifetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: walks a word-aligned fetch PC through imem and buffers
// {pc, instruction} pairs in a DEPTH-entry circular queue for an in-order consumer.
module ifetch_queue #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic [5:0]    imem_addr,
    input  logic [N-1:0]  imem_q,
    input  logic          redirect,
    input  logic [63:0]   redirect_pc,
    output logic [N-1:0]  instr,
    output logic [63:0]   instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N-1:0]     instr_mem_q [DEPTH];
    logic [N-1:0]     instr_mem_d [DEPTH];
    logic [63:0]      pc_mem_q [DEPTH];
    logic [63:0]      pc_mem_d [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Handshake decode; redirect suppresses both push and pop
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_W'(DEPTH));
        pop   = ~empty & instr_ready & ~redirect;
        push  = ~redirect & (~full | pop);
    end

    // Next-state for fetch PC, pointers and occupancy count
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Tail write of the fetched word and its PC
    always_comb begin
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (push) begin
            instr_mem_d[tail_q] = imem_q;
            pc_mem_d[tail_q]    = fetch_pc_q;
        end
    end

    // Control state; synchronous reset wins over redirect, push and pop
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; left uncleared since entries are invisible while count is zero
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

    // Outputs derived only from registered state
    always_comb begin
        imem_addr   = fetch_pc_q[7:2];
        instr_valid = ~empty;
        instr       = empty ? '0 : instr_mem_q[head_q];
        instr_pc    = empty ? '0 : pc_mem_q[head_q];
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized checks of ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

    localparam int DEPTH_TB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic [31:0] imem [64];

    int n_chk = 0;
    int n_bad = 0;

    logic [63:0] mq_pc [$];
    logic [31:0] mq_in [$];
    logic [63:0] m_fpc = '0;

    ifetch_queue #(.N(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    assign imem_q = imem[imem_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock, updating the reference model with the inputs in force
    task automatic cyc();
        bit m_pop;
        bit m_push;
        m_pop  = (mq_pc.size() != 0) && instr_ready && !redirect;
        m_push = !redirect && ((mq_pc.size() < DEPTH_TB) || m_pop);
        if (reset) begin
            mq_pc.delete();
            mq_in.delete();
            m_fpc = '0;
        end else if (redirect) begin
            mq_pc.delete();
            mq_in.delete();
            m_fpc = redirect_pc;
        end else begin
            if (m_pop) begin
                void'(mq_pc.pop_front());
                void'(mq_in.pop_front());
            end
            if (m_push) begin
                mq_pc.push_back(m_fpc);
                mq_in.push_back(imem[m_fpc[7:2]]);
                m_fpc = m_fpc + 64'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        bit ne;
        ne = (mq_pc.size() != 0);
        check({tag, "_valid"}, 64'(instr_valid), 64'(ne));
        check({tag, "_instr"}, 64'(instr), ne ? 64'(mq_in[0]) : 64'd0);
        check({tag, "_pc"}, instr_pc, ne ? mq_pc[0] : 64'd0);
        check({tag, "_addr"}, 64'(imem_addr), 64'(m_fpc[7:2]));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0100_0000 + 32'(i);
        imem[0]  = 32'hf800_0001;
        imem[1]  = 32'hf800_8002;
        imem[2]  = 32'hf800_0203;
        imem[23] = 32'hf840_000c;

        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
        @(posedge clk); #1;
        cyc();
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", instr_pc, 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);

        // Streaming with consumer always ready
        reset = 1'b0;
        cyc();
        check("s0_instr", 64'(instr), 64'hf800_0001);
        check("s0_pc", instr_pc, 64'h0);
        cyc();
        check("s1_instr", 64'(instr), 64'hf800_8002);
        check("s1_pc", instr_pc, 64'h4);
        cyc();
        check("s2_instr", 64'(instr), 64'hf800_0203);
        check("s2_pc", instr_pc, 64'h8);

        // Stalled consumer fills the queue, then drains in order
        reset = 1'b1; instr_ready = 1'b0;
        cyc();
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check("stall_instr", 64'(instr), 64'hf800_0001);
            if (k >= 4) check("stall_addr", 64'(imem_addr), 64'd4);
        end
        check("stall_valid", 64'(instr_valid), 64'd1);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_pc", instr_pc, 64'(4 * k));
            check("drain_instr", 64'(instr), 64'(imem[k]));
            cyc();
        end

        // Redirect while full
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        redirect = 1'b1; redirect_pc = 64'h5C;
        cyc();
        redirect = 1'b0;
        check("redir_valid", 64'(instr_valid), 64'd0);
        check("redir_addr", 64'(imem_addr), 64'd23);
        cyc();
        check("redir_instr", 64'(instr), 64'hf840_000c);
        check("redir_pc", instr_pc, 64'h5C);

        // Address wrap through fetch_pc bits
        redirect = 1'b1; redirect_pc = 64'hF8; instr_ready = 1'b1;
        cyc();
        redirect = 1'b0;
        check("wrap_a0", 64'(imem_addr), 64'd62);
        cyc();
        check("wrap_a1", 64'(imem_addr), 64'd63);
        check("wrap_p0", instr_pc, 64'hF8);
        cyc();
        check("wrap_a2", 64'(imem_addr), 64'd0);
        check("wrap_p1", instr_pc, 64'hFC);
        cyc();
        check("wrap_a3", 64'(imem_addr), 64'd1);
        check("wrap_p2", instr_pc, 64'h100);
        check("wrap_i2", 64'(instr), 64'hf800_0001);
        cyc();
        check("wrap_p3", instr_pc, 64'h104);

        // Reset overrides a simultaneous redirect with three entries queued
        reset = 1'b1; instr_ready = 1'b0;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h40;
        cyc();
        reset = 1'b0; redirect = 1'b0;
        check("rr_valid", 64'(instr_valid), 64'd0);
        check("rr_addr", 64'(imem_addr), 64'd0);
        cyc();
        check("rr_pc", instr_pc, 64'd0);
        check("rr_instr", 64'(instr), 64'hf800_0001);

        // Random consumer backpressure with occasional redirect / reset
        for (int k = 0; k < 500; k++) begin
            instr_ready = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 31) == 0);
            redirect_pc = {$urandom, $urandom};
            reset       = ($urandom_range(0, 63) == 0);
            cyc();
            cmp_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
